ahbl_sram_ctrl: RTL

AHB-Lite slave that initiates accesses on the single-port 4K x 32 on-chip SRAM macro port: EN, 4-bit byte WE, 12-bit word address, 32-bit write data, and registered read data with 1-cycle latency. It converts pipelined AHB address/data phases into SRAM cycles, generates byte-lane strobes, stalls one cycle on write-then-read port collisions, and returns two-cycle ERROR for illegal transfers. It sits between the AHB-Lite bus matrix and the SRAM instance.

---
 rtl/ahbl_pkg.sv | 27 ++
 rtl/ahbl_byte_lanes.sv | 29 ++
 rtl/ahbl_sram_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and controller state type for the SRAM slave.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // WR is the write data phase, COLL the cycle after a write/read port collision,
  // ERR1/ERR2 the two cycles of an ERROR response.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_COLL,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahbl_byte_lanes.sv
// Byte-lane strobe and alignment check for one AHB address phase.
module ahbl_byte_lanes
  import ahbl_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       illegal
);

  // Decode transfer size and low address bits into lanes; flag misalignment and oversize.
  always_comb begin
    mask    = 4'b0000;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
        illegal = addr_lo[0];
      end
      HSIZE_WORD: begin
        mask    = 4'b1111;
        illegal = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite slave front end for a single-port 32-bit SRAM macro with 1-cycle read latency.
// Reads issue in the address phase; writes issue in the data phase, so a read
// right behind a write collides on the port and costs one wait state.
module ahbl_sram_ctrl
  import ahbl_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic          SRAM_EN,
  output logic [3:0]    SRAM_WE,
  output logic [AW-1:0] SRAM_A,
  output logic [31:0]   SRAM_Di,
  input  logic [31:0]   SRAM_Do
);

  state_e        state_q, state_d;
  logic [AW-1:0] dp_addr_q;
  logic [3:0]    dp_mask_q;
  logic [3:0]    lane_mask;
  logic          illegal, accept, coll, acc_pt, cap;

  // Upper address bits alias onto the array; HTRANS[0] only separates NONSEQ/SEQ.
  logic unused_ok;
  assign unused_ok = ^{HADDR[31:AW+2], HTRANS[0]};

  ahbl_byte_lanes u_lanes (
    .hsize   (HSIZE),
    .addr_lo (HADDR[1:0]),
    .mask    (lane_mask),
    .illegal (illegal)
  );

  assign accept = HSEL & HTRANS[1] & HREADY;
  // A read arriving while the write owns the port; independent of HREADY so the
  // stall never loops back through the bus ready mux.
  assign coll   = (state_q == ST_WR) & HSEL & HTRANS[1] & ~HWRITE;

  // Bus response: ready/error/read data from the data-phase state only.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    if (!HRESET) begin
      case (state_q)
        ST_RD:   HRDATA = SRAM_Do;
        ST_WR:   HREADYOUT = ~coll;
        ST_ERR1: begin
          HREADYOUT = 1'b0;
          HRESP     = HRESP_ERROR;
        end
        ST_ERR2: HRESP = HRESP_ERROR;
        default: ;
      endcase
    end
  end

  // Next state and SRAM port drive; reset blanks the port so no write lands.
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    acc_pt  = 1'b0;
    SRAM_EN = 1'b0;
    SRAM_WE = 4'b0000;
    SRAM_A  = '0;
    SRAM_Di = '0;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      ST_WR: begin
        SRAM_EN = 1'b1;
        SRAM_WE = dp_mask_q;
        SRAM_A  = dp_addr_q;
        SRAM_Di = HWDATA;
        if (coll) state_d = ST_COLL;
        else      acc_pt  = 1'b1;
      end
      default: acc_pt = 1'b1;
    endcase
    if (acc_pt) begin
      if (!accept) begin
        state_d = ST_IDLE;
      end else if (illegal) begin
        state_d = ST_ERR1;
      end else if (HWRITE) begin
        state_d = ST_WR;
        cap     = 1'b1;
      end else begin
        state_d = ST_RD;
        SRAM_EN = 1'b1;
        SRAM_WE = 4'b0000;
        SRAM_A  = HADDR[AW+1:2];
      end
    end
    if (HRESET) begin
      SRAM_EN = 1'b0;
      SRAM_WE = 4'b0000;
      SRAM_A  = '0;
      SRAM_Di = '0;
    end
  end

  // State register plus write address/lanes held for the data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      dp_addr_q <= '0;
      dp_mask_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (cap) begin
        dp_addr_q <= HADDR[AW+1:2];
        dp_mask_q <= lane_mask;
      end
    end
  end

endmodule
